fetch_unit: RTL and testbench

- Program-counter and fetch stage feeding the 9-bit instruction ROM; holds the PC and drives the ROM address.
- Captures the returned 9-bit instruction into an IF/ID pipeline register for the decoder.
- Handles start, stall, taken-branch redirect with flush, halt detection, and out-of-range fetch fault.

---
 rtl/fetch_pkg.sv | 26 ++
 rtl/fetch_unit_if.sv | 28 ++
 rtl/fetch_perf_counters.sv | 45 ++++
 rtl/fetch_unit.sv | 153 +++++++++++++++
 tb/tb_fetch_unit.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage.
//   - fetch_state_e : fetch FSM state encoding
//   - INSTR_W/PC_W  : instruction and program-counter widths
//   - HALT_INSTR_DEF: default encoding of the halt instruction
//   - field slices  : {format[8], opcode[7:4], sign[3], operand[2:0]}
package fetch_pkg;

  localparam int INSTR_W = 9;
  localparam int PC_W    = 16;

  localparam logic [INSTR_W-1:0] HALT_INSTR_DEF = 9'b110110000;

  localparam int FMT_BIT  = 8;
  localparam int OPC_HI   = 7;
  localparam int OPC_LO   = 4;
  localparam int SIGN_BIT = 3;
  localparam int OPND_HI  = 2;
  localparam int OPND_LO  = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-side bus: ROM address/data plus the IF/ID register toward the decoder.
//   master (fetch unit): drives pc_out, if_instr, if_pc, if_valid; reads rom_instr
//   slave  (ROM/decoder): reads pc_out and IF/ID fields; drives rom_instr
interface fetch_unit_if;
  import fetch_pkg::*;

  logic [PC_W-1:0]    pc_out;
  logic [INSTR_W-1:0] rom_instr;
  logic [INSTR_W-1:0] if_instr;
  logic [PC_W-1:0]    if_pc;
  logic               if_valid;

  modport master (
    output pc_out,
    input  rom_instr,
    output if_instr,
    output if_pc,
    output if_valid
  );

  modport slave (
    input  pc_out,
    output rom_instr,
    input  if_instr,
    input  if_pc,
    input  if_valid
  );
endinterface

// File: rtl/fetch_perf_counters.sv
// Saturating fetch/stall event counters for the fetch stage.
//   clk, reset   : clock, synchronous active-high reset
//   clr_i        : synchronous clear (accepted start)
//   fetch_inc_i  : one instruction latched into IF/ID this cycle
//   stall_inc_i  : one stalled RUN cycle
//   fetch_count_o, stall_count_o : counts, saturating at FFFF
module fetch_perf_counters (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr_i,
  input  logic        fetch_inc_i,
  input  logic        stall_inc_i,
  output logic [15:0] fetch_count_o,
  output logic [15:0] stall_count_o
);

  logic [15:0] fetch_cnt_q, fetch_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (clr_i) begin
      fetch_cnt_d = '0;
      stall_cnt_d = '0;
    end else begin
      if (fetch_inc_i && (fetch_cnt_q != 16'hFFFF)) fetch_cnt_d = fetch_cnt_q + 16'd1;
      if (stall_inc_i && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fetch_count_o = fetch_cnt_q;
  assign stall_count_o = stall_cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// Program counter and fetch stage: addresses the instruction ROM and captures
// the returned word into the IF/ID register.
//   clk, reset          : clock, synchronous active-high reset
//   start               : one-cycle pulse, begin fetching at START_PC
//   stall               : hold PC and IF/ID
//   br_taken, br_target : redirect from execute (flushes the current fetch)
//   bus (master)        : pc_out / rom_instr / if_instr / if_pc / if_valid
//   halted, fault       : sticky stop flags
// Optional: define FETCH_PERF_EN to add fetch_count / stall_count outputs.
//
// state   | meaning
// --------+-----------------------------------------------------
// ST_IDLE | after reset, waiting for start
// RUN     | fetching one word per cycle
// ST_HALT | halt word seen or fetch fault; waiting for start
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0]    START_PC   = 16'd0,
  parameter int unsigned        ROM_DEPTH  = 120,
  parameter logic [INSTR_W-1:0] HALT_INSTR = HALT_INSTR_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            stall,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_target,
  fetch_unit_if.master    bus,
  output logic            halted,
  output logic            fault
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]     fetch_count,
  output logic [15:0]     stall_count
`endif
);

  localparam logic [PC_W-1:0] DEPTH_PC = PC_W'(ROM_DEPTH);

  fetch_state_e       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] if_instr_q, if_instr_d;
  logic [PC_W-1:0]    if_pc_q, if_pc_d;
  logic               if_valid_q, if_valid_d;
  logic               halted_q, halted_d;
  logic               fault_q, fault_d;

  logic in_range;
  logic is_halt;

  assign in_range = (pc_q < DEPTH_PC);
  assign is_halt  = (bus.rom_instr == HALT_INSTR);

  // State register (all sequential state)
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      pc_q       <= '0;
      if_instr_q <= '0;
      if_pc_q    <= '0;
      if_valid_q <= 1'b0;
      halted_q   <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
      if_valid_q <= if_valid_d;
      halted_q   <= halted_d;
      fault_q    <= fault_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_HALT: if (start) state_d = ST_RUN;
      ST_RUN: begin
        // Branch and stall both keep running; a flushed halt word is ignored.
        if (!br_taken && !stall && (!in_range || is_halt)) state_d = ST_HALT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath / output next values
  always_comb begin
    pc_d       = pc_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
    if_valid_d = if_valid_q;
    halted_d   = halted_q;
    fault_d    = fault_q;
    unique case (state_q)
      ST_RUN: begin
        if (br_taken) begin
          pc_d       = br_target;
          if_valid_d = 1'b0;
        end else if (!stall) begin
          if (!in_range) begin
            if_valid_d = 1'b0;
            fault_d    = 1'b1;
            halted_d   = 1'b1;
          end else begin
            if_instr_d = bus.rom_instr;
            if_pc_d    = pc_q;
            if_valid_d = 1'b1;
            // The halt word reaches the decoder but the PC parks on it.
            if (is_halt) halted_d = 1'b1;
            else         pc_d     = pc_q + 16'd1;
          end
        end
      end
      default: begin
        if_valid_d = 1'b0;
        if (start) begin
          pc_d     = START_PC;
          halted_d = 1'b0;
          fault_d  = 1'b0;
        end
      end
    endcase
  end

  assign bus.pc_out   = pc_q;
  assign bus.if_instr = if_instr_q;
  assign bus.if_pc    = if_pc_q;
  assign bus.if_valid = if_valid_q;
  assign halted       = halted_q;
  assign fault        = fault_q;

`ifdef FETCH_PERF_EN
  logic perf_clr, perf_fetch, perf_stall;

  assign perf_clr   = start && (state_q != ST_RUN);
  assign perf_fetch = (state_q == ST_RUN) && !br_taken && !stall && in_range;
  assign perf_stall = (state_q == ST_RUN) && stall && !br_taken;

  fetch_perf_counters u_perf (
    .clk           (clk),
    .reset         (reset),
    .clr_i         (perf_clr),
    .fetch_inc_i   (perf_fetch),
    .stall_inc_i   (perf_stall),
    .fetch_count_o (fetch_count),
    .stall_count_o (stall_count)
  );
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random
// start/stall/branch/reset traffic, compared every cycle against a
// transaction-level model of the fetch stage.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int          START = 0;
  localparam int          DEPTH = 120;
  localparam logic [8:0]  HALT  = 9'b110110000;

  logic        clk = 1'b0;
  logic        reset, start, stall, br_taken;
  logic [15:0] br_target;
  logic        halted, fault;
`ifdef FETCH_PERF_EN
  logic [15:0] fetch_count, stall_count;
`endif

  always #5 clk = ~clk;

  fetch_unit_if bus ();

  fetch_unit #(
    .START_PC  (16'd0),
    .ROM_DEPTH (120),
    .HALT_INSTR(9'b110110000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stall      (stall),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .bus        (bus.master),
    .halted     (halted),
    .fault      (fault)
`ifdef FETCH_PERF_EN
    ,
    .fetch_count(fetch_count),
    .stall_count(stall_count)
`endif
  );

  logic [8:0] rom [0:255];

  always_comb begin
    bus.rom_instr = 9'h000;
    if (bus.pc_out < 16'd256) bus.rom_instr = rom[bus.pc_out[7:0]];
  end

  // Reference model
  bit         m_active;
  int         m_pc, m_ifpc, m_fc, m_sc;
  logic [8:0] m_instr;
  bit         m_valid, m_halted, m_fault;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    if (reset) begin
      m_active = 0; m_pc = 0; m_instr = '0; m_ifpc = 0;
      m_valid = 0; m_halted = 0; m_fault = 0; m_fc = 0; m_sc = 0;
    end else if (!m_active) begin
      if (start) begin
        m_pc = START; m_halted = 0; m_fault = 0; m_active = 1;
        m_fc = 0; m_sc = 0;
      end
      m_valid = 0;
    end else if (br_taken) begin
      m_pc = br_target;
      m_valid = 0;
    end else if (stall) begin
      if (m_sc < 65535) m_sc++;
    end else if (m_pc >= DEPTH) begin
      m_valid = 0; m_fault = 1; m_halted = 1; m_active = 0;
    end else begin
      m_instr = rom[m_pc];
      m_ifpc  = m_pc;
      m_valid = 1;
      if (m_fc < 65535) m_fc++;
      if (m_instr == HALT) begin
        m_halted = 1; m_active = 0;
      end else begin
        m_pc = (m_pc + 1) % 65536;
      end
    end
  endtask

  task automatic check_all();
    chk("pc_out",   32'(bus.pc_out),   32'(m_pc));
    chk("if_instr", 32'(bus.if_instr), 32'(m_instr));
    chk("if_pc",    32'(bus.if_pc),    32'(m_ifpc));
    chk("if_valid", 32'(bus.if_valid), 32'(m_valid));
    chk("halted",   32'(halted),       32'(m_halted));
    chk("fault",    32'(fault),        32'(m_fault));
`ifdef FETCH_PERF_EN
    chk("fetch_count", 32'(fetch_count), 32'(m_fc));
    chk("stall_count", 32'(stall_count), 32'(m_sc));
`endif
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic drive(input bit r, input bit s, input bit st, input bit b, input int tgt);
    reset = r; start = s; stall = st; br_taken = b; br_target = 16'(tgt);
    tick();
  endtask

  initial begin
    reset = 1; start = 0; stall = 0; br_taken = 0; br_target = '0;
    for (int i = 0; i < 256; i++) rom[i] = 9'(i + 16'h10);
    rom[119] = HALT;

    // Reset, then idle with stall/branch asserted (ignored)
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    chk("rst_pc", 32'(bus.pc_out), 32'd0);
    chk("rst_valid", 32'(bus.if_valid), 32'd0);
    drive(0, 0, 1, 1, 33);

    // Straight-line fetch to PC=5, then branch to 40
    drive(0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 0);
    chk("pre_br_pc", 32'(bus.pc_out), 32'd5);
    drive(0, 0, 0, 1, 40);
    chk("br_bubble", 32'(bus.if_valid), 32'd0);
    drive(0, 0, 0, 0, 0);
    chk("br_ifpc", 32'(bus.if_pc), 32'd40);
    chk("br_instr", 32'(bus.if_instr), 32'(9'd40 + 9'h10));
    drive(0, 1, 0, 0, 0);  // start while running is ignored

    // Stall three cycles at PC=10
    drive(0, 0, 0, 1, 9);
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 0, 0);
      chk("stall_pc", 32'(bus.pc_out), 32'd10);
      chk("stall_ifpc", 32'(bus.if_pc), 32'd9);
    end
    drive(0, 0, 0, 0, 0);
    chk("resume_ifpc", 32'(bus.if_pc), 32'd10);
    drive(0, 0, 1, 1, 100);  // branch wins over stall
    chk("stall_br_pc", 32'(bus.pc_out), 32'd100);

    // Run into the halt word at 119
    for (int i = 0; i < 25; i++) drive(0, 0, 0, 0, 0);
    chk("halt_pc", 32'(bus.pc_out), 32'd119);
    chk("halt_flag", 32'(halted), 32'd1);
    drive(0, 0, 1, 1, 7);    // ignored in HALT
    drive(0, 1, 0, 0, 0);
    chk("restart_halted", 32'(halted), 32'd0);

    // Out-of-range fetch, restart, mid-run reset
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 200);
    drive(0, 0, 0, 0, 0);
    chk("fault_flag", 32'(fault), 32'd1);
    drive(0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    chk("restart_fault", 32'(fault), 32'd0);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    chk("midrst_valid", 32'(bus.if_valid), 32'd0);

    // Random traffic over a random ROM with a few halt words
    for (int i = 0; i < 256; i++) begin
      logic [8:0] w;
      w = 9'($urandom);
      if (w == HALT) w = w ^ 9'h001;
      rom[i] = w;
    end
    for (int i = 0; i < 3; i++) rom[$urandom_range(20, 119)] = HALT;
    drive(0, 1, 0, 0, 0);
    for (int c = 0; c < 800; c++) begin
      drive($urandom_range(0, 99) < 2,
            $urandom_range(0, 99) < 8,
            $urandom_range(0, 99) < 25,
            $urandom_range(0, 99) < 10,
            $urandom_range(0, 130));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
